// File: rtl/sram_bist_pkg.sv
// Shared definitions for the March C- SRAM BIST sequencer: FSM states and the
// March element table.
package sram_bist_pkg;

  localparam int NUM_ELEM = 6;
  localparam logic [2:0] LAST_ELEM = 3'(NUM_ELEM - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // One bit per element, bit i = element Mi.
  //   M0 up w0 | M1 up r0,w1 | M2 up r1,w0 | M3 dn r0,w1 | M4 dn r1,w0 | M5 dn r0
  localparam logic [NUM_ELEM-1:0] ELEM_DOWN = 6'b111000;
  localparam logic [NUM_ELEM-1:0] ELEM_TWO  = 6'b011110;
  localparam logic [NUM_ELEM-1:0] OP0_RD    = 6'b111110;
  localparam logic [NUM_ELEM-1:0] OP0_BG    = 6'b010100;
  localparam logic [NUM_ELEM-1:0] OP1_BG    = 6'b001010;

  // The second operation of a two-op element is always a write.
  function automatic logic op_is_read(input logic [2:0] elem, input logic op);
    op_is_read = op ? 1'b0 : OP0_RD[elem];
  endfunction

  function automatic logic op_bg(input logic [2:0] elem, input logic op);
    op_bg = op ? OP1_BG[elem] : OP0_BG[elem];
  endfunction

endpackage

// File: rtl/sram_bist_addr_gen.sv
// Up/down address counter for the March sequencer: load-to-start, step and
// last-address flag in the current direction.
module sram_bist_addr_gen #(
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              load_down_i,
  input  logic              step_i,
  input  logic              down_i,
  output logic [ADDR_W-1:0] addr_nxt_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] addr_q;

  always_comb begin
    addr_nxt_o = addr_q;
    if (load_i)
      addr_nxt_o = load_down_i ? '1 : '0;
    else if (step_i)
      addr_nxt_o = down_i ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
  end

  assign last_o = down_i ? (addr_q == '0) : (addr_q == '1);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) addr_q <= '0;
    else         addr_q <= addr_nxt_o;
  end

endmodule

// File: rtl/sram_march_bist_ctrl.sv
// March C- BIST sequencer driving the BIST port of one SG13G2 SRAM macro.
// Define SRAM_BIST_DIAG_EN to add first-failure address/bits/element outputs.
module sram_march_bist_ctrl
  import sram_bist_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  output logic              bist_en_o,
  output logic              bist_men_o,
  output logic              bist_wen_o,
  output logic              bist_ren_o,
  output logic [ADDR_W-1:0] bist_addr_o,
  output logic [DATA_W-1:0] bist_din_o,
  output logic [DATA_W-1:0] bist_bm_o,
  input  logic [DATA_W-1:0] dout_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              fail_o
`ifdef SRAM_BIST_DIAG_EN
  ,
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic [DATA_W-1:0] fail_bits_o,
  output logic [2:0]        fail_elem_o
`endif
);

  state_t            state_q;
  logic [2:0]        elem_q;
  logic              op_q;
  logic [2:0]        nxt_elem;
  logic              nxt_op, nxt_rd, nxt_bg;
  logic              start_ok, last_op, last_addr, elem_end, run_end, issue;
  logic              gen_load, gen_step;
  logic [ADDR_W-1:0] addr_nxt;
  logic              vld_p1;
  logic [DATA_W-1:0] exp_p1;
  logic              mismatch_p1;
`ifdef SRAM_BIST_DIAG_EN
  logic [ADDR_W-1:0] addr_p1;
  logic [2:0]        elem_p1;
`endif

  // elem_q/op_q always describe the operation currently on the macro port.
  always_comb begin
    start_ok = start_i && (state_q == IDLE || state_q == DONE);
    last_op  = op_q || !ELEM_TWO[elem_q];
    elem_end = last_op && last_addr;
    run_end  = elem_end && (elem_q == LAST_ELEM);
    issue    = start_ok || (state_q == RUN && !run_end);
    nxt_elem = elem_q;
    nxt_op   = 1'b0;
    if (start_ok)
      nxt_elem = 3'd0;
    else if (state_q == RUN) begin
      if (!last_op)                nxt_op   = 1'b1;
      else if (elem_end && !run_end) nxt_elem = elem_q + 3'd1;
    end
    nxt_rd   = op_is_read(nxt_elem, nxt_op);
    nxt_bg   = op_bg(nxt_elem, nxt_op);
    gen_load = start_ok || (state_q == RUN && elem_end && !run_end);
    gen_step = (state_q == RUN) && last_op && !last_addr;
  end

  sram_bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (gen_load),
    .load_down_i (ELEM_DOWN[nxt_elem]),
    .step_i      (gen_step),
    .down_i      (ELEM_DOWN[elem_q]),
    .addr_nxt_o  (addr_nxt),
    .last_o      (last_addr)
  );

  assign mismatch_p1 = vld_p1 && (dout_i != exp_p1);

  // Stage p0 -> p1: a read on the port becomes a pending compare next cycle.
  always_ff @(posedge clk_i) begin
    exp_p1 <= {DATA_W{op_bg(elem_q, op_q)}};
`ifdef SRAM_BIST_DIAG_EN
    addr_p1 <= bist_addr_o;
    elem_p1 <= elem_q;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      elem_q      <= 3'd0;
      op_q        <= 1'b0;
      vld_p1      <= 1'b0;
      bist_en_o   <= 1'b0;
      bist_men_o  <= 1'b0;
      bist_wen_o  <= 1'b0;
      bist_ren_o  <= 1'b0;
      bist_addr_o <= '0;
      bist_din_o  <= '0;
      bist_bm_o   <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      fail_o      <= 1'b0;
`ifdef SRAM_BIST_DIAG_EN
      fail_addr_o <= '0;
      fail_bits_o <= '0;
      fail_elem_o <= 3'd0;
`endif
    end else begin
      vld_p1 <= bist_ren_o;
      if (issue) begin
        elem_q      <= nxt_elem;
        op_q        <= nxt_op;
        bist_men_o  <= 1'b1;
        bist_wen_o  <= !nxt_rd;
        bist_ren_o  <= nxt_rd;
        bist_addr_o <= addr_nxt;
        bist_din_o  <= nxt_rd ? '0 : {DATA_W{nxt_bg}};
      end
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q   <= RUN;
            bist_en_o <= 1'b1;
            bist_bm_o <= '1;
            busy_o    <= 1'b1;
            done_o    <= 1'b0;
            fail_o    <= 1'b0;
`ifdef SRAM_BIST_DIAG_EN
            fail_addr_o <= '0;
            fail_bits_o <= '0;
            fail_elem_o <= 3'd0;
`endif
          end
        end
        RUN: begin
          if (run_end) begin
            state_q     <= DRAIN;
            bist_men_o  <= 1'b0;
            bist_wen_o  <= 1'b0;
            bist_ren_o  <= 1'b0;
            bist_addr_o <= '0;
            bist_din_o  <= '0;
          end
        end
        DRAIN: begin
          state_q   <= DONE;
          bist_en_o <= 1'b0;
          bist_bm_o <= '0;
          busy_o    <= 1'b0;
          done_o    <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
      // Stage p1 compare; vld_p1 is never set in IDLE/DONE, so no clash with restart.
      if (mismatch_p1) begin
        fail_o <= 1'b1;
`ifdef SRAM_BIST_DIAG_EN
        if (!fail_o) begin
          fail_addr_o <= addr_p1;
          fail_bits_o <= dout_i ^ exp_p1;
          fail_elem_o <= elem_p1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_sram_march_bist_ctrl.sv
// Self-checking bench for sram_march_bist_ctrl with a behavioural SRAM and a
// March C- reference built from the element table (ADDR_W=4, DATA_W=16).
module tb_sram_march_bist_ctrl;

  localparam int AW   = 4;
  localparam int DW   = 16;
  localparam int N    = 1 << AW;
  localparam int NOPS = 10 * N;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic [DW-1:0] dout_i = '0;
  logic          bist_en_o, bist_men_o, bist_wen_o, bist_ren_o;
  logic [AW-1:0] bist_addr_o;
  logic [DW-1:0] bist_din_o, bist_bm_o;
  logic          busy_o, done_o, fail_o;
`ifdef SRAM_BIST_DIAG_EN
  logic [AW-1:0] fail_addr_o;
  logic [DW-1:0] fail_bits_o;
  logic [2:0]    fail_elem_o;
`endif

  sram_march_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .bist_en_o   (bist_en_o),
    .bist_men_o  (bist_men_o),
    .bist_wen_o  (bist_wen_o),
    .bist_ren_o  (bist_ren_o),
    .bist_addr_o (bist_addr_o),
    .bist_din_o  (bist_din_o),
    .bist_bm_o   (bist_bm_o),
    .dout_i      (dout_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .fail_o      (fail_o)
`ifdef SRAM_BIST_DIAG_EN
    ,
    .fail_addr_o (fail_addr_o),
    .fail_bits_o (fail_bits_o),
    .fail_elem_o (fail_elem_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Fault modes: 0 none, 1 stuck-at-1 bit 3 at address 5,
  // 2 write-1 to address 9 forces address 8 bit 0 to 1.
  int            fault_mode = 0;
  logic [DW-1:0] mem [N];

  always @(posedge clk) begin
    if (bist_en_o && bist_men_o) begin
      if (bist_wen_o) begin
        mem[bist_addr_o] = (mem[bist_addr_o] & ~bist_bm_o) | (bist_din_o & bist_bm_o);
        if (fault_mode == 2 && bist_addr_o == AW'(9) && mem[9] == '1) mem[8][0] = 1'b1;
      end else if (bist_ren_o) begin
        dout_i <= (fault_mode == 1 && bist_addr_o == AW'(5)) ? (mem[5] | 16'h0008)
                                                              : mem[bist_addr_o];
      end
    end
  end

  // Reference March C- op list, generated from the algorithm description.
  typedef struct packed {
    logic          rd;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [2:0]    e;
  } op_t;

  op_t ops [NOPS];
  int  n_of  [6]    = '{1, 2, 2, 2, 2, 1};
  bit  dn_of [6]    = '{0, 0, 0, 1, 1, 1};
  bit  rd_of [6][2] = '{'{0,0}, '{1,0}, '{1,0}, '{1,0}, '{1,0}, '{1,0}};
  bit  bg_of [6][2] = '{'{0,0}, '{0,1}, '{1,0}, '{0,1}, '{1,0}, '{0,0}};

  int            exp_kf;
  logic [AW-1:0] exp_faddr;
  logic [DW-1:0] exp_fbits;
  logic [2:0]    exp_felem;

  task automatic build_ops();
    int k = 0;
    for (int e = 0; e < 6; e++)
      for (int i = 0; i < N; i++)
        for (int j = 0; j < n_of[e]; j++) begin
          ops[k].rd = rd_of[e][j];
          ops[k].a  = AW'(dn_of[e] ? N - 1 - i : i);
          ops[k].d  = {DW{bg_of[e][j]}};
          ops[k].e  = 3'(e);
          k++;
        end
  endtask

  // Replay the op list on an abstract faulty memory to find the first miscompare.
  task automatic predict(input int mode);
    logic [DW-1:0] m [N];
    logic [DW-1:0] v;
    exp_kf = 0; exp_faddr = '0; exp_fbits = '0; exp_felem = '0;
    for (int i = 0; i < N; i++) m[i] = '0;
    for (int k = 0; k < NOPS; k++) begin
      if (!ops[k].rd) begin
        m[ops[k].a] = ops[k].d;
        if (mode == 2 && ops[k].a == AW'(9) && ops[k].d == '1) m[8][0] = 1'b1;
      end else begin
        v = m[ops[k].a];
        if (mode == 1 && ops[k].a == AW'(5)) v[3] = 1'b1;
        if (v != ops[k].d && exp_kf == 0) begin
          exp_kf    = k + 1;
          exp_faddr = ops[k].a;
          exp_fbits = v ^ ops[k].d;
          exp_felem = ops[k].e;
        end
      end
    end
  endtask

  // Start a run and check every cycle up to DONE; optionally reset at abort_at.
  task automatic run_march(input int mode, input bit hold, input int abort_at);
    logic [4+AW+2*DW+1:0] got, exp;
    bit exp_fail;
    fault_mode = mode;
    for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
    predict(mode);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    start_i = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= NOPS + 2; c++) begin
      @(negedge clk);
      if (!hold || c > NOPS) start_i = 1'b0;
      got = {bist_en_o, bist_men_o, bist_wen_o, bist_ren_o, bist_addr_o,
             bist_din_o, bist_bm_o, busy_o, done_o};
      if (c <= NOPS)
        exp = {1'b1, 1'b1, !ops[c-1].rd, ops[c-1].rd, ops[c-1].a,
               (ops[c-1].rd ? {DW{1'b0}} : ops[c-1].d), {DW{1'b1}}, 1'b1, 1'b0};
      else if (c == NOPS + 1)
        exp = {4'b1000, {AW{1'b0}}, {DW{1'b0}}, {DW{1'b1}}, 2'b10};
      else
        exp = {4'b0000, {AW{1'b0}}, {DW{1'b0}}, {DW{1'b0}}, 2'b01};
      checks++;
      if (got !== exp)
        $display("FAIL trace mode=%0d cycle=%0d got=%h exp=%h", mode, c, got, exp);
      else passed++;
      exp_fail = (exp_kf != 0) && (c >= exp_kf + 2);
      checks++;
      if (fail_o !== exp_fail)
        $display("FAIL fail_o mode=%0d cycle=%0d got=%b exp=%b", mode, c, fail_o, exp_fail);
      else passed++;
      if (c == abort_at) begin
        rst_ni = 1'b0;
        @(negedge clk);
        got = {bist_en_o, bist_men_o, bist_wen_o, bist_ren_o, bist_addr_o,
               bist_din_o, bist_bm_o, busy_o, done_o};
        checks++;
        if (got !== '0 || fail_o !== 1'b0)
          $display("FAIL mid_reset got=%h fail=%b exp=0", got, fail_o);
        else passed++;
`ifdef SRAM_BIST_DIAG_EN
        checks++;
        if ({fail_addr_o, fail_bits_o, fail_elem_o} !== '0)
          $display("FAIL mid_reset_diag got=%h exp=0", {fail_addr_o, fail_bits_o, fail_elem_o});
        else passed++;
`endif
        rst_ni = 1'b1;
        return;
      end
    end
`ifdef SRAM_BIST_DIAG_EN
    checks++;
    if (fail_addr_o !== exp_faddr || fail_bits_o !== exp_fbits || fail_elem_o !== exp_felem)
      $display("FAIL diag mode=%0d got=%h/%h/%0d exp=%h/%h/%0d", mode,
               fail_addr_o, fail_bits_o, fail_elem_o, exp_faddr, exp_fbits, exp_felem);
    else passed++;
`endif
  endtask

  task automatic test_reset();
    logic [4+AW+2*DW+2:0] got;
    rst_ni = 1'b0;
    start_i = 1'b1;
    repeat (3) @(negedge clk);
    got = {bist_en_o, bist_men_o, bist_wen_o, bist_ren_o, bist_addr_o,
           bist_din_o, bist_bm_o, busy_o, done_o, fail_o};
    checks++;
    if (got !== '0) $display("FAIL reset_outputs got=%h exp=0", got);
    else passed++;
`ifdef SRAM_BIST_DIAG_EN
    checks++;
    if ({fail_addr_o, fail_bits_o, fail_elem_o} !== '0)
      $display("FAIL reset_diag got=%h exp=0", {fail_addr_o, fail_bits_o, fail_elem_o});
    else passed++;
`endif
    start_i = 1'b0;
    rst_ni = 1'b1;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || bist_en_o !== 1'b0)
      $display("FAIL idle_after_reset busy=%b en=%b exp=0", busy_o, bist_en_o);
    else passed++;
  endtask

  task automatic test_clean_run();      run_march(0, 1'b0, 0); endtask
  task automatic test_stuck_at();       run_march(1, 1'b0, 0); endtask
  task automatic test_restart_clean();  run_march(0, 1'b0, 0); endtask
  task automatic test_coupling();       run_march(2, 1'b0, 0); endtask
  task automatic test_start_held();     run_march(0, 1'b1, 0); endtask

  task automatic test_reset_mid_run();
    run_march(1, 1'b0, 50);
    run_march(0, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    run_march(2, 1'b0, 0);
    run_march(1, 1'b0, 0);
  endtask

  initial begin
    build_ops();
    test_reset();
    test_clean_run();
    test_stuck_at();
    test_restart_clean();
    test_coupling();
    test_reset_mid_run();
    test_start_held();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
